gpio_controller: RTL and testbench
==================================

// Module: gpio_controller
// PURPOSE
//  Parametrised memory-mapped GPIO block on the shared data bus: per-pin direction, output latch with atomic
//  set/clear/toggle, metastability-synchronised input sampling, per-pin rising/falling edge interrupts.
//  Single active-high level irq to the core's interrupt input. Bus semantics as all data-bus peripherals.
// PARAMETERS
//  PIN_COUNT    16         number of GPIO pins, 1..32; register bits [31:PIN_COUNT] read 0, writes ignored
//  BASE_ADDR    32'h4034   byte address of first register; word aligned
//  SYNC_STAGES  2          input synchroniser depth, 2..4
// PORTS
//  clk            in     1          system clock, all state on posedge
//  reset          in     1          asynchronous, active-low
//  data_bus_data  inout  32         read data driven when selected, else 'z; write data sampled
//  data_bus_addr  in     32         byte address
//  data_bus_mode  in     2          00 idle, 01 read, 10 write, 11 treated as idle
//  gpio_pins      inout  PIN_COUNT  pin[i] = OUT[i] when DIR[i]=1, else 'z
//  irq            out    1          |(IRQ_PEND), from registered state only
// BEHAVIOUR
//  Map (offset from BASE_ADDR): 00 DIR rw | 04 OUT rw | 08 IN ro | 0C SET wo | 10 CLR wo | 14 TGL wo
//   | 18 RISE_EN rw | 1C FALL_EN rw | 20 IRQ_PEND r/w1c. Any other address: no drive, no write.
//  Reset (async, reset=0): DIR, OUT, RISE_EN, FALL_EN, IRQ_PEND, sync chain, edge-prev reg -> 0;
//   all pins 'z; irq=0; data_bus_data 'z. Takes effect immediately, aborts any bus access in flight.
//  Read: combinational; data_bus_data = zero-extended register while mode==01 and address hits map.
//   SET/CLR/TGL read 0. IN returns last synchroniser stage. Zero wait states.
//  Write: on posedge clk with mode==10 and address hit, using data_bus_data[PIN_COUNT-1:0].
//   SET: OUT|=d; CLR: OUT&=~d; TGL: OUT^=d; writes to IN ignored. Effect visible on pins next cycle.
//  Input path: SYNC_STAGES flop chain per pin, then prev register (prev<=sync every cycle).
//   Pin change visible in IN after SYNC_STAGES posedges; sampled regardless of DIR (loopback).
//  Edge detect: rise[i]=sync[i]&~prev[i]&RISE_EN[i]; fall[i]=~sync[i]&prev[i]&FALL_EN[i].
//   IRQ_PEND[i] set on rise|fall; pending visible SYNC_STAGES+1 cycles after pin edge; irq same cycle.
//   W1C: write to IRQ_PEND clears bits where d=1. Same-cycle edge and clear on one bit: set wins.
//   Clearing an enable does not clear an already-pending bit. Enable bit change applies to the
//   next compare; edges before enable are lost (no retroactive pending).
//  Pin high through reset release: sync ramps 0->1 while enables are 0, so no pending is produced.
//  Pulses shorter than one clk period may be missed; no debounce (software concern).
// TESTING
//  1 Reset: reset=0 mid-write -> all regs read 0, pins 'z, irq=0, bus 'z when mode=00.
//  2 DIR=0x00FF, OUT=0x1234 -> pins[7:0]=0x34, pins[15:8]='z; read OUT=0x00001234.
//  3 OUT=0x00F0; SET 0x000F -> 0x00FF; CLR 0x0030 -> 0x00CF; TGL 0x0101 -> 0x01CE.
//  4 DIR=0, external pins=0xA5A5 -> IN reads 0 for 1 cycle, 0x0000A5A5 at cycle SYNC_STAGES.
//  5 RISE_EN=0x0001, pin0 0->1 -> IRQ_PEND=1, irq=1 at cycle 3 (SYNC_STAGES=2); pin0 1->0 -> no
//   change; write 0x1 to IRQ_PEND -> irq=0 next cycle.
//  6 FALL_EN=0x0004, W1C of bit2 in same cycle as pin2 falling compare -> IRQ_PEND[2] stays 1;
//   unmapped addr BASE_ADDR+0x24 read -> bus 'z; PIN_COUNT=8 build: read DIR bits[31:8]=0.

Source files
------------

// File: rtl/gpio_controller.sv
// ---------------------------------------------------------------------------
// gpio_controller
//   Memory-mapped GPIO block on the shared data bus.
//   - Each pin has its own direction bit.
//   - The output latch supports atomic set, clear and toggle writes.
//   - Every pin input passes through a synchroniser and is readable on IN,
//     whatever its direction (loopback).
//   - Each pin can raise a rising- or falling-edge interrupt into a
//     write-1-to-clear pending register.
//   - irq is the OR of all pending bits.
//
// Ports
//   clk            system clock, all state on posedge
//   reset          asynchronous, active-low
//   data_bus_data  inout [31:0]. Read data is driven while a mapped register
//                  is being read. Write data is sampled on a write.
//   data_bus_addr  byte address
//   data_bus_mode  00 idle, 01 read, 10 write, 11 idle
//   gpio_pins      inout [PIN_COUNT-1:0]. Pin i carries OUT[i] when DIR[i]=1,
//                  otherwise it is released.
//   irq            level interrupt, |IRQ_PEND
//
// Register offsets from BASE_ADDR
//   00 DIR   04 OUT   08 IN   0C SET   10 CLR   14 TGL
//   18 RISE_EN   1C FALL_EN   20 IRQ_PEND
// ---------------------------------------------------------------------------

// Per-pin input path: synchroniser chain followed by the edge-compare
// register (prev follows the last sync stage every cycle).
module gpio_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_i,
    output logic sync_o,
    output logic prev_o
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pin_i};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign prev_o = prev_q;
endmodule

module gpio_controller #(
    parameter int          PIN_COUNT   = 16,
    parameter logic [31:0] BASE_ADDR   = 32'h4034,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    inout  wire  [31:0]          data_bus_data,
    input  logic [31:0]          data_bus_addr,
    input  logic [1:0]           data_bus_mode,
    inout  wire  [PIN_COUNT-1:0] gpio_pins,
    output logic                 irq
);
    localparam logic [3:0] R_DIR  = 4'd0, R_OUT  = 4'd1, R_IN   = 4'd2,
                           R_SET  = 4'd3, R_CLR  = 4'd4, R_TGL  = 4'd5,
                           R_RISE = 4'd6, R_FALL = 4'd7, R_PEND = 4'd8;

    logic [PIN_COUNT-1:0] dir_q, dir_d;
    logic [PIN_COUNT-1:0] out_q, out_d;
    logic [PIN_COUNT-1:0] rise_en_q, rise_en_d;
    logic [PIN_COUNT-1:0] fall_en_q, fall_en_d;
    logic [PIN_COUNT-1:0] pend_q, pend_d;
    logic [PIN_COUNT-1:0] sync_w, prev_w, edge_w, wdata;
    logic [31:0]          offset, rdata;
    logic [3:0]           reg_idx;
    logic                 hit, rd_en, wr_en;

    // Out-of-range or below-base addresses wrap to a large offset and miss.
    assign offset  = data_bus_addr - BASE_ADDR;
    assign hit     = (offset < 32'h24) && (offset[1:0] == 2'b00);
    assign reg_idx = offset[5:2];
    // Reset also releases the bus, so an aborted read never drives stale data.
    assign rd_en   = reset && (data_bus_mode == 2'b01) && hit;
    assign wr_en   = (data_bus_mode == 2'b10) && hit;
    assign wdata   = data_bus_data[PIN_COUNT-1:0];

    for (genvar i = 0; i < PIN_COUNT; i++) begin : g_pin
        assign gpio_pins[i] = dir_q[i] ? out_q[i] : 1'bz;
        gpio_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk    (clk),
            .reset  (reset),
            .pin_i  (gpio_pins[i]),
            .sync_o (sync_w[i]),
            .prev_o (prev_w[i])
        );
    end

    assign edge_w = (sync_w & ~prev_w & rise_en_q) | (~sync_w & prev_w & fall_en_q);

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (reg_idx)
                R_DIR:   rdata[PIN_COUNT-1:0] = dir_q;
                R_OUT:   rdata[PIN_COUNT-1:0] = out_q;
                R_IN:    rdata[PIN_COUNT-1:0] = sync_w;
                R_RISE:  rdata[PIN_COUNT-1:0] = rise_en_q;
                R_FALL:  rdata[PIN_COUNT-1:0] = fall_en_q;
                R_PEND:  rdata[PIN_COUNT-1:0] = pend_q;
                default: rdata = '0;   // SET/CLR/TGL are write-only
            endcase
        end
    end

    assign data_bus_data = rd_en ? rdata : 'z;

    always_comb begin
        dir_d     = dir_q;
        out_d     = out_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        pend_d    = pend_q;
        if (wr_en) begin
            case (reg_idx)
                R_DIR:   dir_d     = wdata;
                R_OUT:   out_d     = wdata;
                R_SET:   out_d     = out_q | wdata;
                R_CLR:   out_d     = out_q & ~wdata;
                R_TGL:   out_d     = out_q ^ wdata;
                R_RISE:  rise_en_d = wdata;
                R_FALL:  fall_en_d = wdata;
                R_PEND:  pend_d    = pend_q & ~wdata;
                default: ;
            endcase
        end
        // Applied after the W1C so that a same-cycle edge keeps its bit set.
        pend_d = pend_d | edge_w;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dir_q     <= '0;
            out_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            pend_q    <= '0;
        end else begin
            dir_q     <= dir_d;
            out_q     <= out_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            pend_q    <= pend_d;
        end
    end

    assign irq = |pend_q;
endmodule

// File: tb/tb_gpio_controller.sv
// Bench for gpio_controller (16-pin instance plus an 8-pin instance).
// Both the bus and the pins carry pullups. A released net therefore reads as
// all ones, which tells it apart from a net that the DUT drives.
module tb_gpio_controller;
    localparam int          PC   = 16;
    localparam int          SS   = 2;
    localparam logic [31:0] BASE = 32'h4034;

    logic        clk = 1'b0, reset = 1'b0;
    logic [31:0] addr = '0, bus_val = '0;
    logic [1:0]  mode = '0;
    logic        bus_en = 1'b0, pin_en = 1'b0;
    logic [PC-1:0] pin_val = '0;
    wire  [31:0] bus;
    wire  [PC-1:0] pins;
    wire         irq;

    logic [31:0] addr8 = '0, bus8_val = '0;
    logic [1:0]  mode8 = '0;
    logic        bus8_en = 1'b0;
    wire  [31:0] bus8;
    wire  [7:0]  pins8;
    wire         irq8;

    assign bus  = bus_en  ? bus_val  : 'z;
    assign pins = pin_en  ? pin_val  : 'z;
    assign bus8 = bus8_en ? bus8_val : 'z;
    pullup pu_bus   (bus);
    pullup pu_pins  (pins);
    pullup pu_bus8  (bus8);
    pullup pu_pins8 (pins8);

    always #5 clk = ~clk;

    gpio_controller #(.PIN_COUNT(PC), .BASE_ADDR(BASE), .SYNC_STAGES(SS)) dut (
        .clk(clk), .reset(reset), .data_bus_data(bus), .data_bus_addr(addr),
        .data_bus_mode(mode), .gpio_pins(pins), .irq(irq));

    gpio_controller #(.PIN_COUNT(8), .BASE_ADDR(BASE), .SYNC_STAGES(SS)) dut8 (
        .clk(clk), .reset(reset), .data_bus_data(bus8), .data_bus_addr(addr8),
        .data_bus_mode(mode8), .gpio_pins(pins8), .irq(irq8));

    typedef struct { string name; logic [31:0] exp; } exp_t;
    typedef enum logic [1:0] {OP_WR, OP_RD, OP_PIN} op_e;
    typedef struct { op_e op; logic [7:0] off; logic [31:0] data; logic [31:0] exp; string name; } vec_t;

    exp_t sb[$];
    vec_t tbl[$];
    int checks = 0, errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sb_pop(input logic [31:0] act);
        exp_t e;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty: got %h expected an entry", act);
        end else begin
            e = sb.pop_front();
            check(e.name, act, e.exp);
        end
    endtask

    task automatic bus_wr(input logic [7:0] off, input logic [31:0] d);
        @(negedge clk);
        addr = BASE + 32'(off); mode = 2'b10; bus_val = d; bus_en = 1'b1;
        @(negedge clk);
        mode = 2'b00; bus_en = 1'b0;
    endtask

    task automatic bus_rd(input logic [7:0] off, input logic [31:0] exp, input string name);
        @(negedge clk);
        addr = BASE + 32'(off); mode = 2'b01; bus_en = 1'b0;
        sb.push_back('{name, exp});
        #1 sb_pop(bus);
        mode = 2'b00;
    endtask

    task automatic add(input op_e op, input logic [7:0] off, input logic [31:0] d,
                       input logic [31:0] e, input string name);
        tbl.push_back('{op, off, d, e, name});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Post-reset readback, DIR/OUT on pins, atomic SET/CLR/TGL, write-only regs
        add(OP_RD,  8'h00, 0, 32'h0,      "rst_dir");
        add(OP_RD,  8'h04, 0, 32'h0,      "rst_out");
        add(OP_RD,  8'h18, 0, 32'h0,      "rst_rise_en");
        add(OP_RD,  8'h1C, 0, 32'h0,      "rst_fall_en");
        add(OP_RD,  8'h20, 0, 32'h0,      "rst_pend_high_pins");
        add(OP_RD,  8'h08, 0, 32'h0000FFFF, "rst_in_pullup");
        add(OP_WR,  8'h00, 32'h00FF, 0,   "");
        add(OP_WR,  8'h04, 32'h1234, 0,   "");
        add(OP_PIN, 8'h00, 0, 32'h0000FF34, "pins_dir_ff");   // upper byte released
        add(OP_RD,  8'h04, 0, 32'h00001234, "out_rd");
        add(OP_RD,  8'h00, 0, 32'h000000FF, "dir_rd");
        add(OP_RD,  8'h08, 0, 32'h0000FF34, "in_loopback");
        add(OP_WR,  8'h04, 32'h00F0, 0,   "");
        add(OP_WR,  8'h0C, 32'h000F, 0,   "");
        add(OP_RD,  8'h04, 0, 32'h000000FF, "set");
        add(OP_WR,  8'h10, 32'h0030, 0,   "");
        add(OP_RD,  8'h04, 0, 32'h000000CF, "clr");
        add(OP_WR,  8'h14, 32'h0101, 0,   "");
        add(OP_RD,  8'h04, 0, 32'h000001CE, "tgl");
        add(OP_PIN, 8'h00, 0, 32'h0000FFCE, "pins_after_tgl");
        add(OP_RD,  8'h0C, 0, 32'h0,      "set_reads0");
        add(OP_RD,  8'h10, 0, 32'h0,      "clr_reads0");
        add(OP_RD,  8'h14, 0, 32'h0,      "tgl_reads0");
        add(OP_WR,  8'h08, 32'hFFFF, 0,   "");
        add(OP_RD,  8'h04, 0, 32'h000001CE, "in_write_ignored");
        add(OP_WR,  8'h18, 32'hFFFF0005, 0, "");
        add(OP_RD,  8'h18, 0, 32'h00000005, "rise_en_rd");
        add(OP_WR,  8'h1C, 32'h000A, 0,   "");
        add(OP_RD,  8'h1C, 0, 32'h0000000A, "fall_en_rd");
        add(OP_WR,  8'h18, 32'h0, 0,      "");
        add(OP_WR,  8'h1C, 32'h0, 0,      "");
        add(OP_RD,  8'h20, 0, 32'h0,      "pend_stable_pins");
        add(OP_RD,  8'h24, 0, 32'hFFFFFFFF, "unmapped_24_z");
        add(OP_RD,  8'h02, 0, 32'hFFFFFFFF, "misaligned_z");
        add(OP_WR,  8'h00, 32'h0, 0,      "");

        // Reset state: bus, pins released; irq low
        repeat (2) @(negedge clk);
        #1;
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_pins_z", {16'd0, pins}, 32'h0000FFFF);
        check("rst_bus_z", bus, 32'hFFFFFFFF);
        @(negedge clk) reset = 1'b1;

        foreach (tbl[i]) begin
            case (tbl[i].op)
                OP_WR:  bus_wr(tbl[i].off, tbl[i].data);
                OP_RD:  bus_rd(tbl[i].off, tbl[i].exp, tbl[i].name);
                default: begin
                    sb.push_back('{tbl[i].name, tbl[i].exp});
                    #1 sb_pop({16'd0, pins});
                end
            endcase
        end

        // Mode 11 is idle: no write
        @(negedge clk);
        addr = BASE; mode = 2'b11; bus_val = 32'hFFFF; bus_en = 1'b1;
        @(negedge clk);
        mode = 2'b00; bus_en = 1'b0;
        bus_rd(8'h00, 32'h0, "mode11_no_write");

        // Synchroniser latency: IN lags the pins by SS cycles
        pin_en = 1'b1; pin_val = '0;
        repeat (4) @(negedge clk);
        pin_val = 16'hA5A5;
        for (int k = 1; k <= SS; k++)
            bus_rd(8'h08, (k < SS) ? 32'h0 : 32'h0000A5A5, $sformatf("in_sync_c%0d", k));

        // Rising-edge interrupt: pending and irq appear SS+1 cycles after the edge
        pin_val = '0;
        repeat (4) @(negedge clk);
        bus_wr(8'h18, 32'h1);
        pin_val = 16'h0001;
        for (int k = 1; k <= SS + 1; k++) begin
            @(negedge clk);
            #1 check($sformatf("irq_rise_c%0d", k), {31'd0, irq}, (k == SS + 1) ? 32'd1 : 32'd0);
        end
        bus_rd(8'h20, 32'h1, "pend_rise");
        pin_val = '0;
        repeat (4) @(negedge clk);
        bus_rd(8'h20, 32'h1, "pend_fall_not_enabled");
        bus_wr(8'h20, 32'h1);
        #1 check("irq_after_w1c", {31'd0, irq}, 32'd0);
        bus_rd(8'h20, 32'h0, "pend_w1c");

        // Disabling an enable keeps an already-pending bit
        pin_val = 16'h0001;
        repeat (4) @(negedge clk);
        bus_wr(8'h18, 32'h0);
        bus_rd(8'h20, 32'h1, "pend_kept_after_disable");
        bus_wr(8'h20, 32'h1);

        // An edge seen before its enable is not pending later
        pin_val = 16'h0003;
        repeat (4) @(negedge clk);
        bus_wr(8'h18, 32'h2);
        repeat (3) @(negedge clk);
        bus_rd(8'h20, 32'h0, "no_retroactive_pend");
        bus_wr(8'h18, 32'h0);

        // The fall compare and a W1C land on the same edge: the set wins
        pin_val = 16'h0004;
        repeat (4) @(negedge clk);
        bus_wr(8'h1C, 32'h4);
        pin_val = '0;
        repeat (SS - 1) @(negedge clk);
        bus_wr(8'h20, 32'h4);
        bus_rd(8'h20, 32'h4, "pend_set_wins");
        #1 check("irq_set_wins", {31'd0, irq}, 32'd1);

        // Reset asserted mid-write, while pins are driven and a bit is pending
        pin_en = 1'b0;
        bus_wr(8'h00, 32'hFFFF);
        bus_wr(8'h04, 32'h5A5A);
        @(negedge clk);
        addr = BASE + 32'h04; mode = 2'b10; bus_val = 32'hFFFF; bus_en = 1'b1;
        #2 reset = 1'b0;
        @(negedge clk);
        mode = 2'b00; bus_en = 1'b0;
        #1;
        check("rst2_irq", {31'd0, irq}, 32'd0);
        check("rst2_pins_z", {16'd0, pins}, 32'h0000FFFF);
        check("rst2_bus_z", bus, 32'hFFFFFFFF);
        @(negedge clk) reset = 1'b1;
        bus_rd(8'h00, 32'h0, "rst2_dir");
        bus_rd(8'h04, 32'h0, "rst2_out");
        bus_rd(8'h1C, 32'h0, "rst2_fall_en");
        bus_rd(8'h20, 32'h0, "rst2_pend");

        // 8-pin build: register bits above PIN_COUNT read zero
        @(negedge clk);
        addr8 = BASE; mode8 = 2'b10; bus8_val = 32'hFFFFFFFF; bus8_en = 1'b1;
        @(negedge clk);
        mode8 = 2'b00; bus8_en = 1'b0;
        @(negedge clk);
        mode8 = 2'b01;
        sb.push_back('{"p8_dir_upper0", 32'h000000FF});
        #1 sb_pop(bus8);
        check("p8_pins_driven", {24'd0, pins8}, 32'h0);
        check("p8_irq", {31'd0, irq8}, 32'd0);
        mode8 = 2'b00;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
